// File: rtl/cdb_lane_arbiter.sv
// Round-robin arbiter that moves up to LANES completed FU results per cycle onto
// registered CDB lanes, with flush and synchronous reset clearing the bus.
module cdb_lane_arbiter #(
    parameter int FU_NUM    = 4,
    parameter int LANES     = 2,
    parameter int WORD_SIZE = 32,
    parameter int RB_INDEX  = 3,
    parameter int PTR_W     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [FU_NUM-1:0]             fu_valid,
    input  logic [FU_NUM*WORD_SIZE-1:0]   fu_data,
    input  logic [FU_NUM*WORD_SIZE-1:0]   fu_addr,
    input  logic [FU_NUM*RB_INDEX-1:0]    fu_rb_index,
    output logic [FU_NUM-1:0]             fu_accept,
    output logic [LANES-1:0]              cdb_valid,
    output logic [LANES*WORD_SIZE-1:0]    cdb_data,
    output logic [LANES*WORD_SIZE-1:0]    cdb_addr,
    output logic [LANES*RB_INDEX-1:0]     cdb_rb_index,
    output logic [LANES*PTR_W-1:0]        cdb_fu
);

    logic [PTR_W-1:0]     rr_ptr;
    logic [FU_NUM-1:0]    req;
    logic [WORD_SIZE-1:0] fu_data_a [FU_NUM];
    logic [WORD_SIZE-1:0] fu_addr_a [FU_NUM];
    logic [RB_INDEX-1:0]  fu_tag_a  [FU_NUM];

    // Chained per-lane results: entry k+1 folds in lane k's grant.
    logic [FU_NUM-1:0]    grant_acc [LANES+1];
    logic [PTR_W-1:0]     ptr_acc   [LANES+1];

    // Reset and flush both withhold every grant so no FU loses a result.
    assign req = (reset || flush) ? '0 : fu_valid;

    for (genvar i = 0; i < FU_NUM; i++) begin : g_unpack
        assign fu_data_a[i] = fu_data[i*WORD_SIZE +: WORD_SIZE];
        assign fu_addr_a[i] = fu_addr[i*WORD_SIZE +: WORD_SIZE];
        assign fu_tag_a[i]  = fu_rb_index[i*RB_INDEX +: RB_INDEX];
    end

    assign grant_acc[0] = '0;
    assign ptr_acc[0]   = rr_ptr;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic              hit;
        logic [PTR_W-1:0]  src;
        logic [FU_NUM-1:0] onehot;
        logic [PTR_W:0]    inc;
        logic [PTR_W-1:0]  nxt;

        logic                 v_q;
        logic [WORD_SIZE-1:0] data_q;
        logic [WORD_SIZE-1:0] addr_q;
        logic [RB_INDEX-1:0]  tag_q;
        logic [PTR_W-1:0]     fu_q;

        // Lane k takes the (k+1)-th requester found scanning from rr_ptr.
        always_comb begin : scan
            logic [PTR_W:0] sum;
            int             seen;
            // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
            hit  = 1'b0;
            src  = '0;
            sum  = '0;
            seen = 0;
            for (int j = 0; j < FU_NUM; j++) begin
                sum = {1'b0, rr_ptr} + (PTR_W+1)'(j);
                if (sum >= (PTR_W+1)'(FU_NUM))
                    sum = sum - (PTR_W+1)'(FU_NUM);
                if (req[sum[PTR_W-1:0]]) begin
                    if (seen == k) begin
                        hit = 1'b1;
                        src = sum[PTR_W-1:0];
                    end
                    seen++;
                end
            end
        end

        assign onehot = hit ? (FU_NUM'(1) << src) : '0;
        assign inc    = {1'b0, src} + (PTR_W+1)'(1);
        assign nxt    = (inc == (PTR_W+1)'(FU_NUM)) ? '0 : inc[PTR_W-1:0];

        assign grant_acc[k+1] = grant_acc[k] | onehot;
        assign ptr_acc[k+1]   = hit ? nxt : ptr_acc[k];

        // Payload of an idle lane keeps its last value; only valid drops.
        always_ff @(posedge clk) begin
            if (reset) begin
                v_q    <= 1'b0;
                data_q <= '0;
                addr_q <= '0;
                tag_q  <= '0;
                fu_q   <= '0;
            end else if (flush) begin
                v_q <= 1'b0;
            end else begin
                v_q <= hit;
                if (hit) begin
                    data_q <= fu_data_a[src];
                    addr_q <= fu_addr_a[src];
                    tag_q  <= fu_tag_a[src];
                    fu_q   <= src;
                end
            end
        end

        assign cdb_valid[k]                          = v_q;
        assign cdb_data[k*WORD_SIZE +: WORD_SIZE]    = data_q;
        assign cdb_addr[k*WORD_SIZE +: WORD_SIZE]    = addr_q;
        assign cdb_rb_index[k*RB_INDEX +: RB_INDEX]  = tag_q;
        assign cdb_fu[k*PTR_W +: PTR_W]              = fu_q;
    end

    assign fu_accept = grant_acc[LANES];

    // Pointer lands just past the last granted FU; it holds when nothing is granted.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignment so all flops update together at the edge.
        if (reset || flush)
            rr_ptr <= '0;
        else
            rr_ptr <= ptr_acc[LANES];
    end

endmodule

// File: tb/tb_cdb_lane_arbiter.sv
// Directed and randomised checks of the CDB lane arbiter: grants, lane mapping,
// wrap-around, flush, reset, and a reference-model fairness run.
module tb_cdb_lane_arbiter;

    localparam int FU_NUM    = 4;
    localparam int LANES     = 2;
    localparam int WORD_SIZE = 32;
    localparam int RB_INDEX  = 3;
    localparam int PTR_W     = 2;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        flush;
    logic [FU_NUM-1:0]           fu_valid;
    logic [FU_NUM*WORD_SIZE-1:0] fu_data;
    logic [FU_NUM*WORD_SIZE-1:0] fu_addr;
    logic [FU_NUM*RB_INDEX-1:0]  fu_rb_index;
    logic [FU_NUM-1:0]           fu_accept;
    logic [LANES-1:0]            cdb_valid;
    logic [LANES*WORD_SIZE-1:0]  cdb_data;
    logic [LANES*WORD_SIZE-1:0]  cdb_addr;
    logic [LANES*RB_INDEX-1:0]   cdb_rb_index;
    logic [LANES*PTR_W-1:0]      cdb_fu;

    int n_tests = 0;
    int n_fail  = 0;

    cdb_lane_arbiter #(
        .FU_NUM(FU_NUM), .LANES(LANES), .WORD_SIZE(WORD_SIZE),
        .RB_INDEX(RB_INDEX), .PTR_W(PTR_W)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_data(fu_data), .fu_addr(fu_addr),
        .fu_rb_index(fu_rb_index), .fu_accept(fu_accept),
        .cdb_valid(cdb_valid), .cdb_data(cdb_data), .cdb_addr(cdb_addr),
        .cdb_rb_index(cdb_rb_index), .cdb_fu(cdb_fu)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fu(input int i, input logic v, input logic [31:0] d,
                           input logic [31:0] a, input logic [2:0] t);
        fu_valid[i]              = v;
        fu_data[i*32 +: 32]      = d;
        fu_addr[i*32 +: 32]      = a;
        fu_rb_index[i*3 +: 3]    = t;
    endtask

    task automatic load_std(input logic [3:0] v);
        for (int i = 0; i < FU_NUM; i++)
            load_fu(i, v[i], 32'(100 + i), 32'(200 + i), 3'(i));
    endtask

    // Random-phase reference model state
    logic [3:0]  v_m;
    logic [31:0] d_m [4];
    logic [31:0] a_m [4];
    logic [2:0]  t_m [4];
    int          wait_m [4];
    int          max_wait;
    int          ptr_m;
    logic [3:0]  acc_m;
    logic [1:0]  pv_m;
    logic [68:0] plane_m [2];

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        fu_valid = '0; fu_data = '0; fu_addr = '0; fu_rb_index = '0;

        // T1: reset held for two cycles with every FU requesting
        #1;
        load_std(4'b1111);
        #1;
        check("t1_accept_in_reset", fu_accept, 4'b0000);
        step();
        step();
        check("t1_accept_still_reset", fu_accept, 4'b0000);
        check("t1_cdb_valid", cdb_valid, 2'b00);
        check("t1_cdb_data", cdb_data, 64'h0);
        check("t1_cdb_addr", cdb_addr, 64'h0);
        check("t1_cdb_tag", cdb_rb_index, 6'h0);
        check("t1_cdb_fu", cdb_fu, 4'h0);
        reset = 1'b0;

        // T2: full load from pointer 0, then FU2/FU3 keep holding
        load_std(4'b1111);
        #1;
        check("t2_accept_a", fu_accept, 4'b0011);
        step();
        check("t2_valid_a", cdb_valid, 2'b11);
        check("t2_data_a", cdb_data, {32'd101, 32'd100});
        check("t2_addr_a", cdb_addr, {32'd201, 32'd200});
        check("t2_tag_a", cdb_rb_index, {3'd1, 3'd0});
        check("t2_fu_a", cdb_fu, {2'd1, 2'd0});
        check("t2_accept_b", fu_accept, 4'b1100);
        step();
        check("t2_valid_b", cdb_valid, 2'b11);
        check("t2_data_b", cdb_data, {32'd103, 32'd102});
        check("t2_tag_b", cdb_rb_index, {3'd3, 3'd2});
        check("t2_fu_b", cdb_fu, {2'd3, 2'd2});

        // T3: single requester FU3, pointer back at 0
        load_std(4'b1000);
        fu_data[3*32 +: 32] = 32'hDEAD;
        #1;
        check("t3_accept", fu_accept, 4'b1000);
        step();
        check("t3_valid", cdb_valid, 2'b01);
        check("t3_data", cdb_data[31:0], 32'hDEAD);
        check("t3_fu", cdb_fu[1:0], 2'd3);

        // Steer pointer to 3 via a lone FU2 grant (also proves pointer was 0 -> 2 needs scan)
        load_std(4'b0100);
        #1;
        check("t4_setup_accept", fu_accept, 4'b0100);
        step();
        check("t4_setup_fu", cdb_fu[1:0], 2'd2);

        // T4: wrap-around from pointer 3
        load_std(4'b1011);
        #1;
        check("t4_accept", fu_accept, 4'b1001);
        step();
        check("t4_valid", cdb_valid, 2'b11);
        check("t4_fu", cdb_fu, {2'd0, 2'd3});
        check("t4_data", cdb_data, {32'd100, 32'd103});

        // T5: flush with pointer at 1; previous lanes stay visible during the flush cycle
        load_std(4'b1111);
        flush = 1'b1;
        #1;
        check("t5_accept_flush", fu_accept, 4'b0000);
        check("t5_lanes_visible", cdb_valid, 2'b11);
        step();
        flush = 1'b0;
        #1;
        check("t5_valid_cleared", cdb_valid, 2'b00);
        check("t5_accept_after", fu_accept, 4'b0011);
        step();
        check("t5_data_after", cdb_data, {32'd101, 32'd100});

        // Fewer valids than lanes, scanning from pointer 2 with wrap
        load_std(4'b0101);
        #1;
        check("few_accept", fu_accept, 4'b0101);
        step();
        check("few_valid", cdb_valid, 2'b11);
        check("few_fu", cdb_fu, {2'd0, 2'd2});
        check("few_data", cdb_data, {32'd100, 32'd102});

        // Reset and flush together mid-operation, pointer at 1 beforehand
        load_std(4'b1111);
        reset = 1'b1;
        flush = 1'b1;
        #1;
        check("rf_accept", fu_accept, 4'b0000);
        step();
        reset = 1'b0;
        flush = 1'b0;
        #1;
        check("rf_valid", cdb_valid, 2'b00);
        check("rf_data", cdb_data, 64'h0);
        check("rf_fu", cdb_fu, 4'h0);
        check("rf_accept_after", fu_accept, 4'b0011);

        // T6: random traffic against a reference model, pointer known to be 0
        v_m = '0;
        ptr_m = 0;
        max_wait = 0;
        for (int i = 0; i < 4; i++) begin
            d_m[i] = '0; a_m[i] = '0; t_m[i] = '0; wait_m[i] = 0;
        end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            int nl;
            int last;
            for (int i = 0; i < 4; i++) begin
                if (!v_m[i] && $urandom_range(0, 99) < 55) begin
                    v_m[i]    = 1'b1;
                    d_m[i]    = $urandom;
                    a_m[i]    = $urandom;
                    t_m[i]    = 3'($urandom_range(0, 7));
                    wait_m[i] = 0;
                end
                load_fu(i, v_m[i], d_m[i], a_m[i], t_m[i]);
            end
            #1;
            acc_m = '0;
            nl    = 0;
            last  = 0;
            for (int j = 0; j < 4; j++) begin
                int idx;
                idx = (ptr_m + j) % 4;
                if (v_m[idx] && nl < 2) begin
                    acc_m[idx]  = 1'b1;
                    plane_m[nl] = {d_m[idx], a_m[idx], t_m[idx], 2'(idx)};
                    nl++;
                    last = idx;
                end
            end
            if (nl > 0)
                ptr_m = (last + 1) % 4;
            pv_m = {nl >= 2, nl >= 1};
            check("rand_accept", fu_accept, acc_m);
            for (int i = 0; i < 4; i++) begin
                if (v_m[i]) begin
                    wait_m[i]++;
                    if (acc_m[i]) begin
                        if (wait_m[i] > max_wait)
                            max_wait = wait_m[i];
                        v_m[i] = 1'b0;
                    end
                end
            end
            step();
            check("rand_valid", cdb_valid, pv_m);
            for (int k = 0; k < 2; k++) begin
                if (pv_m[k])
                    check("rand_lane",
                          {cdb_data[k*32 +: 32], cdb_addr[k*32 +: 32],
                           cdb_rb_index[k*3 +: 3], cdb_fu[k*2 +: 2]},
                          plane_m[k]);
            end
        end
        check("rand_max_wait_le_2", max_wait <= 2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
